// File: rtl/uart_tx8_if.sv
// uart_tx8_if: byte-in / serial-out bundle for the uart_tx8 transmitter.
//   txEn     transmitter enable (master -> slave)
//   txStart  byte-valid strobe, accepted when txStart & txReady & txEn
//   txIn     byte to send, sampled on the accept edge
//   txReady  holding register empty (slave -> master)
//   txOut    serial line, idles high
//   txBusy   frame in progress
//   txDone   one-cycle pulse at frame completion
interface uart_tx8_if;
    logic       txEn;
    logic       txStart;
    logic [7:0] txIn;
    logic       txReady;
    logic       txOut;
    logic       txBusy;
    logic       txDone;

    modport master (
        output txEn, txStart, txIn,
        input  txReady, txOut, txBusy, txDone
    );

    modport slave (
        input  txEn, txStart, txIn,
        output txReady, txOut, txBusy, txDone
    );
endinterface

// File: rtl/uart_tx8.sv
// uart_tx8: 8N1 UART transmitter (start bit, 8 data bits LSB first, 1 or 2 stop bits).
// A one-byte holding register lets the next byte be queued while a frame is on the line,
// so consecutive frames go out with no idle gap. All outputs come straight from registers.
// Ports:
//   clk   system clock, rising edge
//   rstN  asynchronous active-low reset
//   bus   uart_tx8_if.slave: txEn, txStart, txIn in; txReady, txOut, txBusy, txDone out
module uart_tx8 #(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned STOP_BITS  = 1
) (
    input logic       clk,
    input logic       rstN,
    uart_tx8_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned CntW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [2:0]      LastStop = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : gBadDivider
        $error("uart_tx8: CLOCK_RATE / BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStopBits
        $error("uart_tx8: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} stateT;

    stateT           state;
    logic [CntW-1:0] divCnt;
    logic [2:0]      bitIdx;    // data bit index in StData, stop bit index in StStop
    logic [7:0]      shifter;
    logic [7:0]      holdReg;
    logic            holdFull;
    logic            lineQ;
    logic            busyQ;
    logic            doneQ;
    logic            accept;

    // Accept and load never coincide: accept needs holding empty, load needs it full.
    assign accept = bus.txStart & ~holdFull & bus.txEn;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= StIdle;
            divCnt   <= '0;
            bitIdx   <= '0;
            shifter  <= '0;
            holdReg  <= '0;
            holdFull <= 1'b0;
            lineQ    <= 1'b1;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            case (state)
                StIdle: begin
                    lineQ <= 1'b1;
                    busyQ <= 1'b0;
                    if (holdFull && bus.txEn) begin
                        shifter  <= holdReg;
                        holdFull <= 1'b0;
                        divCnt   <= '0;
                        lineQ    <= 1'b0;
                        busyQ    <= 1'b1;
                        state    <= StStart;
                    end
                end
                StStart: begin
                    if (divCnt == LastCnt) begin
                        divCnt <= '0;
                        bitIdx <= '0;
                        lineQ  <= shifter[0];
                        state  <= StData;
                    end else begin
                        divCnt <= divCnt + CntOne;
                    end
                end
                StData: begin
                    if (divCnt == LastCnt) begin
                        divCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            bitIdx <= '0;
                            lineQ  <= 1'b1;
                            state  <= StStop;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            lineQ  <= shifter[bitIdx + 3'd1];
                        end
                    end else begin
                        divCnt <= divCnt + CntOne;
                    end
                end
                StStop: begin
                    if (divCnt == LastCnt) begin
                        divCnt <= '0;
                        if (bitIdx == LastStop) begin
                            bitIdx <= '0;
                            doneQ  <= 1'b1;
                            // Chain straight into the next start bit when a byte is waiting.
                            if (holdFull && bus.txEn) begin
                                shifter  <= holdReg;
                                holdFull <= 1'b0;
                                lineQ    <= 1'b0;
                                state    <= StStart;
                            end else begin
                                busyQ <= 1'b0;
                                state <= StIdle;
                            end
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end else begin
                        divCnt <= divCnt + CntOne;
                    end
                end
            endcase

            if (accept) begin
                holdReg  <= bus.txIn;
                holdFull <= 1'b1;
            end
        end
    end

    assign bus.txReady = ~holdFull;
    assign bus.txOut   = lineQ;
    assign bus.txBusy  = busyQ;
    assign bus.txDone  = doneQ;

endmodule

// File: tb/tb_uart_tx8.sv
module tb_uart_tx8;

    logic       clk = 1'b0;
    logic       rstN;
    logic       drvStart;
    logic       drvEn;
    logic [7:0] drvIn;
    int         sel;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx8_if bus0 ();
    uart_tx8_if bus1 ();
    uart_tx8_if bus2 ();

    assign bus0.txStart = drvStart && (sel == 0);
    assign bus1.txStart = drvStart && (sel == 1);
    assign bus2.txStart = drvStart && (sel == 2);
    assign bus0.txEn    = (sel == 0) ? drvEn : 1'b1;
    assign bus1.txEn    = (sel == 1) ? drvEn : 1'b1;
    assign bus2.txEn    = (sel == 2) ? drvEn : 1'b1;
    assign bus0.txIn    = drvIn;
    assign bus1.txIn    = drvIn;
    assign bus2.txIn    = drvIn;

    uart_tx8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600), .STOP_BITS(1)) dut0 (
        .clk(clk), .rstN(rstN), .bus(bus0)
    );
    uart_tx8 #(.CLOCK_RATE(16), .BAUD_RATE(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rstN(rstN), .bus(bus1)
    );
    uart_tx8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600), .STOP_BITS(2)) dut2 (
        .clk(clk), .rstN(rstN), .bus(bus2)
    );

    logic obsOut, obsBusy, obsDone, obsReady;
    always_comb begin
        case (sel)
            0: begin
                obsOut = bus0.txOut; obsBusy = bus0.txBusy;
                obsDone = bus0.txDone; obsReady = bus0.txReady;
            end
            1: begin
                obsOut = bus1.txOut; obsBusy = bus1.txBusy;
                obsDone = bus1.txDone; obsReady = bus1.txReady;
            end
            default: begin
                obsOut = bus2.txOut; obsBusy = bus2.txBusy;
                obsDone = bus2.txDone; obsReady = bus2.txReady;
            end
        endcase
    end

    int nAssert = 0;
    int nFail   = 0;

    // Reference model: each accepted byte is a frame with accept edge a and first
    // start-bit cycle s; the line, busy, done and ready follow from these by arithmetic.
    typedef struct {
        int         a;
        int         s;
        logic [7:0] d;
    } frame_t;
    frame_t fq[$];
    int cpb, sb, flen;

    int       mmCnt;
    int       mmCyc;
    logic [3:0] mmAct, mmExp;
    int       doneCount;
    int       doneCyc[$];

    function automatic logic expLine(input int c);
        logic v = 1'b1;
        foreach (fq[i]) begin
            if (c >= fq[i].s && c < fq[i].s + flen) begin
                int k = (c - fq[i].s) / cpb;
                if (k == 0) v = 1'b0;
                else if (k <= 8) v = fq[i].d[k-1];
                else v = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic expBusy(input int c);
        foreach (fq[i]) if (c >= fq[i].s && c < fq[i].s + flen) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic expDone(input int c);
        foreach (fq[i]) if (c == fq[i].s + flen) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic expReady(input int c);
        foreach (fq[i]) if (c >= fq[i].a && c < fq[i].s) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int lastEnd();
        if (fq.size() == 0) return 0;
        return fq[fq.size()-1].s + flen;
    endfunction

    // Advance one cycle, sample on the falling edge and tally disagreements with the model.
    task automatic step();
        logic [3:0] act, exp;
        @(negedge clk);
        act = {obsOut, obsBusy, obsDone, obsReady};
        exp = {expLine(cyc), expBusy(cyc), expDone(cyc), expReady(cyc)};
        if (act !== exp) begin
            if (mmCnt == 0) begin
                mmCyc = cyc; mmAct = act; mmExp = exp;
            end
            mmCnt++;
        end
        if (obsDone) begin
            doneCount++;
            doneCyc.push_back(cyc);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        if (drvEn && expReady(cyc)) begin
            int st = (cyc + 2 > lastEnd()) ? cyc + 2 : lastEnd();
            fq.push_back('{a: cyc + 1, s: st, d: d});
        end
        drvStart = 1'b1;
        drvIn    = d;
        step();
        drvStart = 1'b0;
        drvIn    = 8'($urandom);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!expReady(cyc) && t < 2000) begin step(); t++; end
    endtask

    task automatic drain(input int extra);
        int lim = lastEnd() + extra;
        while (cyc < lim) step();
    endtask

    task automatic select(input int k);
        sel       = k;
        cpb       = (k == 1) ? 16 : 1250;
        sb        = (k == 2) ? 2 : 1;
        flen      = (9 + sb) * cpb;
        mmCnt     = 0;
        doneCount = 0;
        fq.delete();
        doneCyc.delete();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            nAssert++;
            if (obsOut !== 1'b1) begin
                nFail++; $display("FAIL reset_txOut dut%0d: got %b expected 1", k, obsOut);
            end
            nAssert++;
            if (obsBusy !== 1'b0) begin
                nFail++; $display("FAIL reset_txBusy dut%0d: got %b expected 0", k, obsBusy);
            end
            nAssert++;
            if (obsDone !== 1'b0) begin
                nFail++; $display("FAIL reset_txDone dut%0d: got %b expected 0", k, obsDone);
            end
            nAssert++;
            if (obsReady !== 1'b1) begin
                nFail++; $display("FAIL reset_txReady dut%0d: got %b expected 1", k, obsReady);
            end
        end
    endtask

    task automatic test_single_byte();
        int base, fall, doneC, bFirst, bLast;
        select(0);
        base = cyc;
        while (cyc < base + 9) step();
        write_byte(8'h55);
        fall = -1; doneC = -1; bFirst = -1; bLast = -1;
        repeat (12510) begin
            step();
            if (obsOut == 1'b0 && fall < 0) fall = cyc - base;
            if (obsDone && doneC < 0) doneC = cyc - base;
            if (obsBusy) begin
                if (bFirst < 0) bFirst = cyc - base;
                bLast = cyc - base;
            end
        end
        nAssert++;
        if (mmCnt !== 0) begin
            nFail++;
            $display("FAIL single_frame: %0d cycles differ, first at %0d out/busy/done/ready=%b expected %b",
                     mmCnt, mmCyc, mmAct, mmExp);
        end
        nAssert++;
        if (fall !== 11) begin nFail++; $display("FAIL single_fall: got cycle %0d expected 11", fall); end
        nAssert++;
        if (doneC !== 12511) begin
            nFail++; $display("FAIL single_done: got cycle %0d expected 12511", doneC);
        end
        nAssert++;
        if (bFirst !== 11 || bLast !== 12510) begin
            nFail++; $display("FAIL single_busy: got %0d..%0d expected 11..12510", bFirst, bLast);
        end
    endtask

    task automatic test_back_to_back();
        int busyGap = 0;
        int lim;
        logic lineAtD1 = 1'b1;
        select(1);
        write_byte(8'hA3);
        wait_ready();
        write_byte(8'h0F);
        lim = lastEnd() + 5;
        while (cyc < lim) begin
            step();
            if (cyc >= fq[0].s && cyc < lastEnd() && !obsBusy) busyGap++;
            if (obsDone && doneCount == 1) lineAtD1 = obsOut;
        end
        nAssert++;
        if (mmCnt !== 0) begin
            nFail++;
            $display("FAIL b2b_frames: %0d cycles differ, first at %0d out/busy/done/ready=%b expected %b",
                     mmCnt, mmCyc, mmAct, mmExp);
        end
        nAssert++;
        if (doneCount !== 2) begin nFail++; $display("FAIL b2b_done_count: got %0d expected 2", doneCount); end
        nAssert++;
        if (doneCyc.size() == 2 && doneCyc[1] - doneCyc[0] !== 160) begin
            nFail++; $display("FAIL b2b_done_spacing: got %0d expected 160", doneCyc[1] - doneCyc[0]);
        end
        nAssert++;
        if (busyGap !== 0) begin nFail++; $display("FAIL b2b_busy_gap: got %0d low cycles expected 0", busyGap); end
        nAssert++;
        if (lineAtD1 !== 1'b0) begin
            nFail++; $display("FAIL b2b_start_at_done: txOut got %b expected 0", lineAtD1);
        end
    endtask

    task automatic test_flow_control();
        logic readyAtC;
        select(1);
        write_byte(8'h3C);
        wait_ready();
        write_byte(8'hE1);
        repeat (3) step();
        readyAtC = obsReady;
        write_byte(8'h77);
        wait_ready();
        write_byte(8'h9A);
        drain(5);
        nAssert++;
        if (mmCnt !== 0) begin
            nFail++;
            $display("FAIL flow_frames: %0d cycles differ, first at %0d out/busy/done/ready=%b expected %b",
                     mmCnt, mmCyc, mmAct, mmExp);
        end
        nAssert++;
        if (readyAtC !== 1'b0) begin nFail++; $display("FAIL flow_ready_full: got %b expected 0", readyAtC); end
        nAssert++;
        if (doneCount !== 3) begin nFail++; $display("FAIL flow_done_count: got %0d expected 3", doneCount); end
    endtask

    task automatic test_en_drop();
        select(1);
        write_byte(8'h5A);
        wait_ready();
        write_byte(8'hB4);
        while (cyc < fq[0].s + 3 * cpb + 5) step();
        drvEn = 1'b0;
        fq[1].s = 1 << 30;
        while (cyc < fq[0].s + flen + 40) step();
        nAssert++;
        if (obsOut !== 1'b1 || obsBusy !== 1'b0) begin
            nFail++; $display("FAIL en_idle: txOut/txBusy got %b%b expected 10", obsOut, obsBusy);
        end
        nAssert++;
        if (obsReady !== 1'b0) begin nFail++; $display("FAIL en_pending_kept: txReady got %b expected 0", obsReady); end
        drvEn = 1'b1;
        fq[1].s = cyc + 1;
        step();
        wait_ready();
        drvEn = 1'b0;
        write_byte(8'h11);
        drain(30);
        drvEn = 1'b1;
        repeat (40) step();
        nAssert++;
        if (mmCnt !== 0) begin
            nFail++;
            $display("FAIL en_frames: %0d cycles differ, first at %0d out/busy/done/ready=%b expected %b",
                     mmCnt, mmCyc, mmAct, mmExp);
        end
        nAssert++;
        if (doneCount !== 2) begin nFail++; $display("FAIL en_done_count: got %0d expected 2", doneCount); end
    endtask

    task automatic test_async_reset();
        select(1);
        write_byte(8'hC6);
        wait_ready();
        write_byte(8'h3B);
        while (cyc < fq[0].s + 4 * cpb + 3) step();
        #2 rstN = 1'b0;
        #1;
        nAssert++;
        if (obsOut !== 1'b1) begin nFail++; $display("FAIL areset_txOut: got %b expected 1", obsOut); end
        nAssert++;
        if (obsBusy !== 1'b0) begin nFail++; $display("FAIL areset_txBusy: got %b expected 0", obsBusy); end
        nAssert++;
        if (obsReady !== 1'b1) begin nFail++; $display("FAIL areset_txReady: got %b expected 1", obsReady); end
        fq.delete();
        @(negedge clk);
        rstN = 1'b1;
        repeat (2 * flen + 10) step();
        nAssert++;
        if (mmCnt !== 0) begin
            nFail++;
            $display("FAIL areset_residual: %0d cycles differ, first at %0d out/busy/done/ready=%b expected %b",
                     mmCnt, mmCyc, mmAct, mmExp);
        end
        nAssert++;
        if (doneCount !== 0) begin nFail++; $display("FAIL areset_done: got %0d expected 0", doneCount); end
    endtask

    task automatic test_random();
        select(1);
        repeat (12) begin
            repeat ($urandom_range(0, 200)) step();
            write_byte(8'($urandom));
        end
        drain(10);
        nAssert++;
        if (mmCnt !== 0) begin
            nFail++;
            $display("FAIL random_frames: %0d cycles differ, first at %0d out/busy/done/ready=%b expected %b",
                     mmCnt, mmCyc, mmAct, mmExp);
        end
        nAssert++;
        if (doneCount !== fq.size()) begin
            nFail++; $display("FAIL random_done_count: got %0d expected %0d", doneCount, fq.size());
        end
    endtask

    // Independent mid-bit receiver on the line, as a downstream UART would see it.
    task automatic test_loopback();
        logic [7:0] txB [3];
        logic [7:0] rxData[$];
        logic       rxErr[$];
        int         stopLen[$];
        logic [7:0] data;
        logic       err, prev, rxActive;
        int         fall, off, k, wi, t;
        txB[0] = 8'h00; txB[1] = 8'hFF; txB[2] = 8'h55;
        select(2);
        write_byte(txB[0]);
        wi = 1; t = 0; prev = obsOut; rxActive = 1'b0; fall = 0; data = '0; err = 1'b0;
        while ((rxData.size() < 3 || stopLen.size() < 3) && t < 45000) begin
            if (wi < 3 && expReady(cyc)) begin
                write_byte(txB[wi]);
                wi++;
            end else begin
                step();
            end
            t++;
            if (obsDone) stopLen.push_back(cyc - (fall + 9 * cpb));
            if (!rxActive && prev && !obsOut) begin
                rxActive = 1'b1; fall = cyc; data = '0; err = 1'b0;
            end else if (rxActive) begin
                off = cyc - fall;
                if (off % cpb == cpb / 2) begin
                    k = off / cpb;
                    if (k == 0) begin
                        if (obsOut) err = 1'b1;
                    end else if (k <= 8) begin
                        data[k-1] = obsOut;
                    end else begin
                        if (!obsOut) err = 1'b1;
                        if (k == 8 + sb) begin
                            rxActive = 1'b0;
                            rxData.push_back(data);
                            rxErr.push_back(err);
                        end
                    end
                end
            end
            prev = obsOut;
        end
        nAssert++;
        if (rxData.size() !== 3 || stopLen.size() !== 3) begin
            nFail++;
            $display("FAIL loop_count: got %0d bytes %0d done pulses expected 3 and 3",
                     rxData.size(), stopLen.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < rxData.size()) begin
                nAssert++;
                if (rxData[i] !== txB[i]) begin
                    nFail++; $display("FAIL loop_byte%0d: got %h expected %h", i, rxData[i], txB[i]);
                end
                nAssert++;
                if (rxErr[i] !== 1'b0) begin
                    nFail++; $display("FAIL loop_rxErr%0d: got %b expected 0", i, rxErr[i]);
                end
            end
            if (i < stopLen.size()) begin
                nAssert++;
                if (stopLen[i] !== 2500) begin
                    nFail++; $display("FAIL loop_stop%0d: got %0d cycles expected 2500", i, stopLen[i]);
                end
            end
        end
        nAssert++;
        if (mmCnt !== 0) begin
            nFail++;
            $display("FAIL loop_frames: %0d cycles differ, first at %0d out/busy/done/ready=%b expected %b",
                     mmCnt, mmCyc, mmAct, mmExp);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN     = 1'b0;
        drvStart = 1'b0;
        drvEn    = 1'b1;
        drvIn    = 8'h00;
        sel      = 0;
        #12;
        test_reset();
        @(negedge clk);
        rstN = 1'b1;
        test_single_byte();
        test_back_to_back();
        test_flow_control();
        test_en_drop();
        test_async_reset();
        test_random();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/uart_tx8.md
Name: uart_tx8

Overview:
- 8N1 UART transmitter; the transmit-side counterpart of the existing 8-bit UART receiver (Uart8 rx path).
- Serialises one byte per frame: start bit (0), 8 data bits LSB first, stop bit(s) (1).
- Bit timing comes from an internal clock-cycle divider.
- A one-byte holding register allows back-to-back frames with no idle gap.

Parameters:
- CLOCK_RATE, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- Derived: CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE, integer truncation (1250 at defaults).
- CLKS_PER_BIT < 2 or an illegal STOP_BITS value is an elaboration error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstN  in  1  reset, asynchronous, active-low.
- txEn  in  1  transmitter enable.
- txStart  in  1  byte-valid strobe; accepted when txStart & txReady & txEn.
- txIn  in  8  byte to send; sampled on the accept edge.
- txReady  out  1  holding register empty; a write can be accepted.
- txOut  out  1  serial line, idles high.
- txBusy  out  1  frame in progress (start, data or stop bit being driven).
- txDone  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rstN low, async, takes effect immediately, including mid-frame):
  - txOut=1, txBusy=0, txDone=0, txReady=1.
  - FSM=IDLE; bit/cycle counters=0; holding register emptied, any pending byte discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- Accept:
  - On a rising edge with txStart & txReady & txEn, txIn is written to holding; txReady=0 from the next cycle.
  - txStart with txReady=0 or txEn=0 is ignored; no queuing beyond one byte.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - txOut=1, txBusy=0.
  - If holding full and txEn=1: load shifter from holding, empty holding (txReady=1 next cycle), go to START.
  - Latency: accept at edge N; txOut falls after edge N+1.
- START: txOut=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - txOut=shifter[index] for CLKS_PER_BIT cycles per bit, LSB first.
  - After bit 7, go to STOP.
- STOP: txOut=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end:
  - txDone=1 for exactly one cycle (the first cycle after the last stop cycle).
  - If holding full and txEn=1: load and go directly to START. The start bit begins in that same cycle, so there is no idle gap.
  - Otherwise go to IDLE.
- txBusy:
  - =1 in START/DATA/STOP.
  - Stays continuously 1 across back-to-back frames.
- txEn deasserted mid-frame:
  - The current frame completes normally.
  - A byte already in holding is retained and not started until txEn returns high.
  - New writes are blocked while txEn=0.
- Divider counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps; width is $clog2(CLKS_PER_BIT).
  - Reset to 0 at every state entry.
  - Exact bit period is CLKS_PER_BIT cycles; no accumulated drift within a frame.
- Frame length = (9+STOP_BITS)*CLKS_PER_BIT cycles (12500 at defaults).
- txIn changes after the accept edge have no effect on the frame in flight.

Test Plan:
- Single byte, defaults: write 8'h55 at cycle 10.
  - txOut falls at cycle 11.
  - Bit sequence 0,1,0,1,0,1,0,1,0,1, each 1250 cycles.
  - txDone pulse at cycle 12511; txBusy high for cycles 11..12510.
- Back-to-back, CLOCK_RATE=16, BAUD_RATE=1 (16 clks/bit):
  - Write 8'hA3, then write 8'h0F as soon as txReady=1.
  - Second start bit immediately follows the first stop bit; txBusy never drops; two txDone pulses 160 cycles apart.
- Flow control: second write attempted while holding full → ignored; only 2 frames on the line; third write accepted only after txReady rises.
- txEn drop:
  - Deassert txEn mid-data with a byte pending → frame completes; txOut stays 1 and txBusy=0 while txEn=0.
  - Reassert → pending byte transmits.
- Async reset mid-frame: assert rstN=0 during data bit 3 → txOut=1 immediately without a clock edge; txBusy=0; txReady=1; after release no residual frame is sent.
- Loopback, defaults + STOP_BITS=2:
  - Connect txOut to the existing Uart8 receiver and send 8'h00, 8'hFF, 8'h55.
  - Receiver rxOut matches each byte; rxErr=0; stop period is 2500 cycles.
